face_detection_bridge: RTL and testbench

//  Parametrised Avalon-MM slave between the Linux host and the face_detection core.

---
 rtl/face_detection_bridge.sv | 257 +++++++++++++++++++++++++
 tb/tb_face_detection_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detection_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : face_detection_bridge (+ face_detection_bridge_fifo)        |
// | Purpose  : Avalon-MM slave between the host and the face_detection     |
// |            core. Address-decoded CTRL/STATUS/PIXEL/RESULT/LEVELS       |
// |            registers, a pixel FIFO (host->core) and a result FIFO      |
// |            (core->host) with valid/ready streams, frame-end tagging,   |
// |            sticky status flags and a one-cycle registered soft reset.  |
// | Ports    : s_*        Avalon-MM slave (1-cycle registered read data)    |
// |            core_reset reset to the core (hard or soft reset)           |
// |            pix_*      pixel stream to the core (valid/ready, last tag)  |
// |            res_*      result stream from the core (valid/ready, last)  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

// +------------------------------------------------------------------------+
// | Module   : face_detection_bridge_fifo                                  |
// | Purpose  : Synchronous FIFO with first-word-fall-through head and an   |
// |            occupancy count. Push while full is dropped; pop while      |
// |            empty is ignored.                                           |
// | Ports    : clk_i/rst_i clock and synchronous active-high reset         |
// |            push_i/wdata_i write side, pop_i/head_o read side           |
// |            full_o/empty_o/count_o occupancy                            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module face_detection_bridge_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged before any same-cycle pop, so a push into a full FIFO
  // is always dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

module face_detection_bridge #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 3,
  parameter int RESULT_WIDTH   = 12,
  parameter int PIX_FIFO_DEPTH = 16,
  parameter int RES_FIFO_DEPTH = 16
) (
  input  logic                    s_clk,
  input  logic                    s_reset,
  input  logic [ADDR_WIDTH-1:0]   s_address,
  input  logic                    s_read,
  output logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_write,
  input  logic [DATA_WIDTH-1:0]   s_writedata,
  output logic                    core_reset,
  output logic [DATA_WIDTH-1:0]   pix_data,
  output logic                    pix_last,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  input  logic [RESULT_WIDTH-1:0] res_data,
  input  logic                    res_last,
  input  logic                    res_valid,
  output logic                    res_ready
);

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_PIXEL  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_PIXLST = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_RESULT = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LEVELS = ADDR_WIDTH'(4);

  localparam int PCW = $clog2(PIX_FIFO_DEPTH) + 1;
  localparam int RCW = $clog2(RES_FIFO_DEPTH) + 1;

  // Registered state
  logic                  soft_rst_q, soft_rst_d;
  logic                  enable_q, enable_d;
  logic                  pix_ovf_q, pix_ovf_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] readdata_q, readdata_d;

  // Decode and FIFO interface
  logic                  rst_all;
  logic                  wr_ctrl, wr_pixel, wr_pixlst, rd_result;
  logic                  sticky_clr;
  logic                  pix_push, pix_pop, pix_full, pix_empty;
  logic [DATA_WIDTH:0]   pix_head;
  logic [PCW-1:0]        pix_count;
  logic                  res_push, res_pop, res_full, res_empty;
  logic [RESULT_WIDTH:0] res_head;
  logic [RCW-1:0]        res_count;
  logic [5:0]            status;
  logic [15:0]           levels;
  logic [DATA_WIDTH-1:0] rd_mux;

  // Hard and soft reset act identically on the bridge and the core. Every
  // host access in a reset cycle is discarded by gating the decode.
  assign rst_all    = s_reset | soft_rst_q;
  assign core_reset = rst_all;

  assign wr_ctrl   = s_write && !rst_all && (s_address == c_ADDR_CTRL);
  assign wr_pixel  = s_write && !rst_all && (s_address == c_ADDR_PIXEL);
  assign wr_pixlst = s_write && !rst_all && (s_address == c_ADDR_PIXLST);
  assign rd_result = s_read  && !rst_all && (s_address == c_ADDR_RESULT);

  // A soft-reset write ignores its enable and clear bits.
  assign sticky_clr = wr_ctrl && !s_writedata[0] && s_writedata[2];

  // ---------------- pixel path (host -> core) ----------------
  assign pix_push = wr_pixel | wr_pixlst;
  assign pix_pop  = pix_valid && pix_ready;

  face_detection_bridge_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (PIX_FIFO_DEPTH)
  ) u_pix_fifo (
    .clk_i   (s_clk),
    .rst_i   (rst_all),
    .push_i  (pix_push),
    .pop_i   (pix_pop),
    .wdata_i ({wr_pixlst, s_writedata}),
    .head_o  (pix_head),
    .full_o  (pix_full),
    .empty_o (pix_empty),
    .count_o (pix_count)
  );

  assign pix_valid = !pix_empty && enable_q && !rst_all;
  assign pix_data  = (pix_empty || rst_all) ? '0 : pix_head[DATA_WIDTH-1:0];
  assign pix_last  = (pix_empty || rst_all) ? 1'b0 : pix_head[DATA_WIDTH];

  // ---------------- result path (core -> host) ----------------
  assign res_ready = !res_full && !rst_all;
  assign res_push  = res_valid && res_ready;
  assign res_pop   = rd_result && !res_empty;

  face_detection_bridge_fifo #(
    .WIDTH (RESULT_WIDTH + 1),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i   (s_clk),
    .rst_i   (rst_all),
    .push_i  (res_push),
    .pop_i   (res_pop),
    .wdata_i ({res_last, res_data}),
    .head_o  (res_head),
    .full_o  (res_full),
    .empty_o (res_empty),
    .count_o (res_count)
  );

  // ---------------- read mux ----------------
  assign status = {enable_q, frame_done_q, pix_ovf_q, res_empty, pix_empty, pix_full};
  assign levels = {8'(res_count), 8'(pix_count)};

  always_comb begin
    rd_mux = '0;
    case (s_address)
      c_ADDR_CTRL:   rd_mux = DATA_WIDTH'(status);
      c_ADDR_RESULT: if (!res_empty) rd_mux = DATA_WIDTH'(res_head);
      c_ADDR_LEVELS: rd_mux = DATA_WIDTH'(levels);
      default:       rd_mux = '0;
    endcase
  end

  // ---------------- control / sticky next state ----------------
  always_comb begin
    soft_rst_d   = wr_ctrl && s_writedata[0];
    enable_d     = enable_q;
    pix_ovf_d    = pix_ovf_q;
    frame_done_d = frame_done_q;
    readdata_d   = readdata_q;

    if (wr_ctrl && !s_writedata[0]) enable_d = s_writedata[1];

    // Clear first so that a same-cycle set wins.
    if (sticky_clr) begin
      pix_ovf_d    = 1'b0;
      frame_done_d = 1'b0;
    end
    if (pix_push && pix_full)  pix_ovf_d    = 1'b1;
    if (res_push && res_last)  frame_done_d = 1'b1;

    if (s_read) readdata_d = rd_mux;
  end

  always_ff @(posedge s_clk) begin
    if (rst_all) begin
      soft_rst_q   <= 1'b0;
      enable_q     <= 1'b0;
      pix_ovf_q    <= 1'b0;
      frame_done_q <= 1'b0;
      readdata_q   <= '0;
    end else begin
      soft_rst_q   <= soft_rst_d;
      enable_q     <= enable_d;
      pix_ovf_q    <= pix_ovf_d;
      frame_done_q <= frame_done_d;
      readdata_q   <= readdata_d;
    end
  end

  assign s_readdata = readdata_q;

endmodule
`default_nettype wire

// File: tb/tb_face_detection_bridge.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_face_detection_bridge                                    |
// | Purpose  : Self-checking bench for face_detection_bridge: directed     |
// |            scenarios plus randomized traffic, compared against a       |
// |            queue-based reference model with a scoreboard monitor.      |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_face_detection_bridge;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int RW = 12;
  localparam int PD = 16;
  localparam int RD = 16;

  logic          clk = 1'b0;
  logic          s_reset, s_read, s_write;
  logic [AW-1:0] s_address;
  logic [DW-1:0] s_writedata, s_readdata;
  logic          core_reset;
  logic [DW-1:0] pix_data;
  logic          pix_last, pix_valid, pix_ready;
  logic [RW-1:0] res_data;
  logic          res_last, res_valid, res_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  face_detection_bridge #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .RESULT_WIDTH   (RW),
    .PIX_FIFO_DEPTH (PD),
    .RES_FIFO_DEPTH (RD)
  ) dut (
    .s_clk       (clk),
    .s_reset     (s_reset),
    .s_address   (s_address),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .core_reset  (core_reset),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .res_data    (res_data),
    .res_last    (res_last),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard monitor ----------------
  // Model state reflects the bridge after the most recent clock edge; at
  // each falling edge outputs are compared, then the inputs that the next
  // rising edge will see are applied to the model.
  logic [DW:0]   pq[$];   // expected pixels {last, data}
  logic [RW:0]   rq[$];   // expected results {last, data}
  logic [DW-1:0] rdq[$];  // expected read data
  logic          m_en, m_ovf, m_fd, m_srst;
  bit            m_on = 0;
  bit            rd_pend = 0;

  always @(negedge clk) begin
    logic          rst, exp_pv, rr, pfull, nxt_srst, clr, set_ovf, set_fd;
    logic [DW-1:0] exp_rd;

    if (rd_pend) begin
      check("readdata", s_readdata, rdq.pop_front());
      rd_pend = 0;
    end

    if (s_reset) m_on = 1;

    if (m_on) begin
      rst    = s_reset | m_srst;
      exp_pv = !rst && m_en && (pq.size() != 0);
      rr     = !rst && (rq.size() < RD);
      pfull  = (pq.size() == PD);

      check("core_reset", core_reset, rst);
      check("pix_valid", pix_valid, exp_pv);
      check("res_ready", res_ready, rr);
      if (rst || pq.size() == 0) begin
        check("pix_data_idle", pix_data, 0);
        check("pix_last_idle", pix_last, 0);
      end else begin
        check("pix_data", pix_data, pq[0][DW-1:0]);
        check("pix_last", pix_last, pq[0][DW]);
      end

      if (s_read) begin
        exp_rd = '0;
        if (!rst) begin
          case (s_address)
            0: exp_rd = {10'b0, m_en, m_fd, m_ovf, rq.size() == 0, pq.size() == 0, pq.size() == PD};
            3: if (rq.size() != 0) exp_rd = DW'(rq[0]);
            4: exp_rd = {8'(rq.size()), 8'(pq.size())};
            default: exp_rd = '0;
          endcase
        end
        rdq.push_back(exp_rd);
        rd_pend = 1;
      end

      if (rst) begin
        pq.delete();
        rq.delete();
        m_en = 0; m_ovf = 0; m_fd = 0; m_srst = 0;
      end else begin
        nxt_srst = 0; clr = 0; set_ovf = 0; set_fd = 0;
        if (s_read && s_address == 3 && rq.size() != 0) void'(rq.pop_front());
        if (exp_pv && pix_ready) void'(pq.pop_front());
        if (s_write) begin
          case (s_address)
            0: if (s_writedata[0]) nxt_srst = 1;
               else begin m_en = s_writedata[1]; clr = s_writedata[2]; end
            1, 2: if (pfull) set_ovf = 1;
                  else pq.push_back({s_address == 2, s_writedata});
            default: ;
          endcase
        end
        if (rr && res_valid) begin
          rq.push_back({res_last, res_data});
          if (res_last) set_fd = 1;
        end
        m_ovf  = set_ovf | (m_ovf & !clr);
        m_fd   = set_fd  | (m_fd  & !clr);
        m_srst = nxt_srst;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_reset = 1; cyc(); cyc(); s_reset = 0; #1;
  endtask

  task automatic wr(input int a, input int d);
    s_write = 1; s_address = AW'(a); s_writedata = DW'(d);
    cyc();
    s_write = 0;
  endtask

  task automatic rd_chk(input int a, input int e, input string name);
    s_read = 1; s_address = AW'(a);
    cyc();
    s_read = 0;
    check(name, s_readdata, e);
  endtask

  initial begin
    int            op;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_pix [3];
    exp_pix[0] = 16'h0011; exp_pix[1] = 16'h0022; exp_pix[2] = 16'h0033;

    s_reset = 1; s_read = 0; s_write = 0; s_address = '0; s_writedata = '0;
    pix_ready = 0; res_valid = 0; res_last = 0; res_data = '0;

    // Reset state
    do_reset();
    check("rst_res_ready", res_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_core_reset", core_reset, 0);
    rd_chk(0, 'h06, "rst_status");
    rd_chk(4, 'h00, "rst_levels");

    // Pixel stream with last tag
    wr(0, 'h2); wr(1, 'h11); wr(1, 'h22); wr(2, 'h33);
    pix_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("px_valid", pix_valid, 1);
      check("px_data", pix_data, exp_pix[i]);
      check("px_last", pix_last, (i == 2) ? 1 : 0);
      cyc();
    end
    check("px_drained", pix_valid, 0);
    pix_ready = 0;

    // Overflow with enable off
    wr(0, 'h0);
    for (int i = 0; i < 17; i++) wr(1, 'h100 + i);
    rd_chk(4, 16, "ovf_levels");
    rd_chk(0, 'h0D, "ovf_status");
    wr(0, 'h4);
    rd_chk(0, 'h05, "ovf_cleared");
    do_reset();

    // Results with frame end
    res_valid = 1; res_data = 'h0A5; res_last = 0; cyc();
    res_data = 'h0FF; res_last = 1; cyc();
    res_valid = 0; res_last = 0;
    rd_chk(3, 'h00A5, "res_first");
    rd_chk(3, 'h10FF, "res_last");
    rd_chk(0, 'h16, "res_frame_done");
    rd_chk(3, 'h0000, "res_empty_read");

    // Simultaneous host pop and core push
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      res_valid = 1; res_data = RW'('h100 + i); cyc();
    end
    res_valid = 0;
    rd_chk(4, 'h300, "sim_levels_before");
    s_read = 1; s_address = 3; res_valid = 1; res_data = 'h104;
    cyc();
    s_read = 0; res_valid = 0;
    check("sim_pop_data", s_readdata, 'h101);
    rd_chk(4, 'h300, "sim_levels_after");
    rd_chk(3, 'h102, "sim_order_1");
    rd_chk(3, 'h103, "sim_order_2");
    rd_chk(3, 'h104, "sim_order_3");

    // Soft reset mid-frame
    do_reset();
    wr(0, 'h2);
    for (int i = 0; i < 5; i++) wr(1, 'h40 + i);
    rd_chk(4, 5, "srst_levels_before");
    s_write = 1; s_address = 0; s_writedata = 'h1;
    cyc();
    s_write = 0;
    check("srst_core_reset_on", core_reset, 1);
    check("srst_pix_valid", pix_valid, 0);
    check("srst_res_ready", res_ready, 0);
    s_read = 1; s_address = 4;
    cyc();
    s_read = 0;
    check("srst_core_reset_off", core_reset, 0);
    check("srst_discarded_read", s_readdata, 0);
    rd_chk(4, 0, "srst_levels_after");
    rd_chk(0, 'h06, "srst_status_after");

    // Randomized traffic checked by the monitor
    for (int n = 0; n < 3000; n++) begin
      s_read  = 0;
      s_write = 0;
      s_reset = ($urandom_range(0, 299) == 0);
      op = int'($urandom_range(0, 7));
      case (op)
        0, 1, 2: begin
          s_write = 1; s_address = AW'($urandom_range(1, 2)); s_writedata = DW'($urandom);
        end
        3: begin s_read = 1; s_address = AW'($urandom_range(0, 7)); end
        4: begin s_read = 1; s_address = 3; end
        5: begin
          d = DW'($urandom) & 16'hFFFE;
          if ($urandom_range(0, 31) == 0) d[0] = 1'b1;
          s_write = 1; s_address = 0; s_writedata = d;
        end
        6: begin
          s_write = 1; s_address = AW'($urandom_range(3, 7)); s_writedata = DW'($urandom);
        end
        default: ;
      endcase
      pix_ready = ($urandom_range(0, 1) == 1);
      res_valid = ($urandom_range(0, 1) == 1);
      res_last  = ($urandom_range(0, 7) == 0);
      res_data  = RW'($urandom);
      cyc();
    end

    s_read = 0; s_write = 0; s_reset = 0; pix_ready = 0; res_valid = 0; res_last = 0;
    cyc(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
